// File: rtl/unidad_mult_div.sv
// ---------------------------------------------------------------------------
// unidad_mult_div
//
// Iterative 32-bit multiply/divide unit fed by the register bank read ports.
// Runs MULT/MULTU/DIV/DIVU in 34 cycles from accept to visible result and
// keeps the results in HI/LO, which can also be written directly (MTHI/MTLO).
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   start     : launch an operation (accepted only while idle)
//   op[1:0]   : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A[31:0]   : multiplicand / dividend, also MTHI/MTLO data
//   B[31:0]   : multiplier / divisor
//   wr_hi     : MTHI, HI <= A (idle and no start only)
//   wr_lo     : MTLO, LO <= A (idle and no start only)
//   busy      : operation in progress
//   done      : one-cycle pulse, HI/LO hold the new result
//   div_zero  : with done, divide by zero (or divide unsupported)
//   HI[31:0]  : product high word or remainder
//   LO[31:0]  : product low word or quotient
//
// Configuration
//   MULTDIV_DIV_EN : when defined the restoring divider is built. When not
//                    defined, DIV/DIVU finish after one busy cycle with
//                    div_zero=1 and HI/LO untouched.
// ---------------------------------------------------------------------------
module unidad_mult_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        wr_hi,
  input  logic        wr_lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [4:0]  cnt_r;
  logic        op_div_r;
  logic        neg_a_r;
  logic        neg_b_r;
  // Multiplicand magnitude for multiply, raw dividend for divide.
  logic [31:0] opa_r;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend / quotient bits}.
  logic [63:0] acc_r;
  logic [63:0] acc_nxt_s;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;
  logic        div_zero_r;

  logic        is_signed_s;
  logic        accept_s;
  logic        mt_en_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [32:0] mul_sum_s;
  logic [63:0] prod_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;
  logic        res_wr_s;
  logic        dz_flag_s;

`ifdef MULTDIV_DIV_EN
  logic [31:0] opb_r;
  logic        divz_r;
  logic [32:0] div_shift_s;
  logic [32:0] div_diff_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
`endif

  // Operand decode: magnitudes for signed ops, raw values for unsigned ops
  always_comb begin
    is_signed_s = ~op[0];
    accept_s    = (state_r == ST_IDLE) && start;
    mt_en_s     = (state_r == ST_IDLE) && !start;
    if (is_signed_s && A[31]) begin
      mag_a_s = 32'd0 - A;
    end else begin
      mag_a_s = A;
    end
    if (is_signed_s && B[31]) begin
      mag_b_s = 32'd0 - B;
    end else begin
      mag_b_s = B;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
`ifdef MULTDIV_DIV_EN
          state_nxt_s = ST_RUN;
`else
          // Divide is compiled out: skip straight to the finishing cycle.
          if (op[1]) begin
            state_nxt_s = ST_FIX;
          end else begin
            state_nxt_s = ST_RUN;
          end
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == 5'd31) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FIX:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    acc_nxt_s = acc_r;
    // Add the multiplicand into the high half when the current multiplier
    // bit is set, then shift the whole accumulator right by one.
    mul_sum_s = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opa_r} : 33'd0);
`ifdef MULTDIV_DIV_EN
    // Shift the next dividend bit into the partial remainder and try the
    // subtract; bit 32 of the difference is the borrow.
    div_shift_s = acc_r[63:31];
    div_diff_s  = div_shift_s - {1'b0, opb_r};
    if (op_div_r) begin
      if (!div_diff_s[32]) begin
        acc_nxt_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
      end else begin
        acc_nxt_s = {div_shift_s[31:0], acc_r[30:0], 1'b0};
      end
    end else begin
      acc_nxt_s = {mul_sum_s, acc_r[31:1]};
    end
`else
    acc_nxt_s = {mul_sum_s, acc_r[31:1]};
`endif
  end

  // Operand capture at accept and iteration during RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= 5'd0;
      op_div_r <= 1'b0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      opa_r    <= 32'd0;
      acc_r    <= 64'd0;
`ifdef MULTDIV_DIV_EN
      opb_r    <= 32'd0;
      divz_r   <= 1'b0;
`endif
    end else if (accept_s) begin
      cnt_r    <= 5'd0;
      op_div_r <= op[1];
      neg_a_r  <= is_signed_s & A[31];
      neg_b_r  <= is_signed_s & B[31];
`ifdef MULTDIV_DIV_EN
      opb_r    <= mag_b_s;
      divz_r   <= op[1] & (B == 32'd0);
      if (op[1]) begin
        opa_r <= A;
        acc_r <= {32'd0, mag_a_s};
      end else begin
        opa_r <= mag_a_s;
        acc_r <= {32'd0, mag_b_s};
      end
`else
      opa_r    <= mag_a_s;
      acc_r    <= {32'd0, mag_b_s};
`endif
    end else if (state_r == ST_RUN) begin
      cnt_r <= cnt_r + 5'd1;
      acc_r <= acc_nxt_s;
    end
  end

  // Sign fix-up of the raw magnitude result, evaluated during FIX
  always_comb begin
    if (neg_a_r ^ neg_b_r) begin
      prod_s = 64'd0 - acc_r;
    end else begin
      prod_s = acc_r;
    end
    res_hi_s  = prod_s[63:32];
    res_lo_s  = prod_s[31:0];
    res_wr_s  = 1'b0;
    dz_flag_s = 1'b0;
`ifdef MULTDIV_DIV_EN
    quo_s = acc_r[31:0];
    rem_s = acc_r[63:32];
    if (state_r == ST_FIX) begin
      res_wr_s  = 1'b1;
      dz_flag_s = op_div_r & divz_r;
    end else begin
      res_wr_s  = 1'b0;
      dz_flag_s = 1'b0;
    end
    if (op_div_r) begin
      if (divz_r) begin
        res_hi_s = opa_r;
        res_lo_s = 32'hFFFF_FFFF;
      end else begin
        // Quotient truncates toward zero; remainder follows the dividend.
        res_lo_s = (neg_a_r ^ neg_b_r) ? (32'd0 - quo_s) : quo_s;
        res_hi_s = neg_a_r ? (32'd0 - rem_s) : rem_s;
      end
    end else begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end
`else
    if (state_r == ST_FIX) begin
      // An unsupported divide leaves HI/LO alone and reports div_zero.
      res_wr_s  = ~op_div_r;
      dz_flag_s = op_div_r;
    end else begin
      res_wr_s  = 1'b0;
      dz_flag_s = 1'b0;
    end
`endif
  end

  // HI/LO: result write on leaving FIX, otherwise MTHI/MTLO while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (res_wr_s) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else if (mt_en_s) begin
      if (wr_hi) begin
        hi_r <= A;
      end
      if (wr_lo) begin
        lo_r <= A;
      end
    end
  end

  // Registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      busy_r     <= (state_nxt_s != ST_IDLE);
      done_r     <= (state_r == ST_FIX);
      div_zero_r <= dz_flag_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign HI       = hi_r;
  assign LO       = lo_r;

endmodule
